mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multiply/divide unit for the EX stage; successor to the fixed 32-bit mult/div block.
- Adds configurable data width and multiplier pipeline depth, an integrated radix-2 iterative divider, and multiply-accumulate/subtract ops against a supplied HI/LO value.
- Uses an explicit start/busy/done handshake, defined divide-by-zero results, and flush abort.
- The EX stage stalls on busy and writes {hi,lo} to HI/LO on done.

Parameters:
DATA_WIDTH, 32, operand width W; result is 2W.
MULT_STAGES, 2, multiply latency in cycles from accept to done (1..4).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
flush  input  1  abort current operation (pipeline flush/exception).
start  input  1  request; accepted only when busy=0 and flush=0.
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
operand_1  input  W  rs value (dividend / multiplicand).
operand_2  input  W  rt value (divisor / multiplier).
hilo_in  input  2W  current {HI,LO}; used by ops 4-7, sampled at accept.
busy  output  1  operation in flight.
done  output  1  one-cycle pulse when result is valid.
result  output  2W  {hi,lo}; held stable from done until the next accept.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, busy=0, done=0, result=0. Reset overrides start and flush. Reset mid-operation discards the operation with no done.
- Accept: start & !busy & !flush at a posedge.
  - Latch op, operand_1, operand_2 and hilo_in.
  - busy=1 from the next cycle.
  - The cycle done is high is also the cycle busy falls, so a new start may be accepted on the cycle after done.
- start while busy is ignored; no queueing.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX.
  - IDLE -> MUL on accept of op 0,1,4-7.
  - IDLE -> DIV_PREP on accept of op 2,3.
  - flush in any state -> IDLE next cycle; no done; result unchanged.
- Sign handling: ops 0,2,4,6 are signed; 1,3,5,7 are unsigned.
- Multiply:
  - Full 2W product of the sign-correct operands; signed uses two's-complement sign extension.
  - Ops 4/5: result = hilo_in + product, mod 2^(2W).
  - Ops 6/7: result = hilo_in - product, mod 2^(2W).
  - done asserts exactly MULT_STAGES cycles after the accept edge.
  - The product may be pipelined internally; MULT_STAGES sets only the done latency.
- Divide:
  - DIV_PREP (1 cycle): take magnitudes of signed operands.
    - If divisor == 0: go to DIV_FIX directly, with quotient = all ones and remainder = operand_1 (raw, no sign fix). done 2 cycles after accept.
  - DIV_ITER (W cycles): restoring radix-2, one quotient bit per cycle, MSB first; W-bit iteration counter.
  - DIV_FIX (1 cycle): negate the quotient if operand signs differ; negate the remainder if the dividend is negative.
    - Result = {remainder, quotient}; done pulses.
  - Nonzero-divisor latency: done W+2 cycles after accept (34 for W=32).
  - Signed overflow, INT_MIN / -1: quotient = INT_MIN, remainder = 0; no trap.
  - Invariant for divisor != 0: dividend == quotient*divisor + remainder, with |remainder| < |divisor| and the remainder taking the dividend's sign.
- Simultaneous events:
  - flush & start in the same cycle: flush wins; start is not accepted.
  - flush in the done cycle: done still asserts, because the result was registered at the prior edge. A flush arriving before the done edge suppresses done.
- done is never asserted for two consecutive cycles from one operation.

Test Plan:
- MULT W=32, MULT_STAGES=2: 0xFFFFFFFF * 0x00000002 -> done 2 cycles after accept, result 0xFFFFFFFF_FFFFFFFE; MULTU with the same operands -> 0x00000001_FFFFFFFE.
- MADD: hilo_in=0x00000000_00000010, -3 * 5 -> result 0x00000000_00000001; MSUBU: hilo_in=0, 1*1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV -7 / 2 -> done 34 cycles after accept, hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); DIVU 7 / 2 -> hi=1, lo=3; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide-by-zero: DIVU 0x1234 / 0 -> done 2 cycles after accept, hi=0x00001234, lo=0xFFFFFFFF.
- Flush at cycle 10 of a DIV -> IDLE next cycle, no done, busy=0, previous result unchanged; start held while busy -> ignored.
- rst=1 mid-DIV -> busy=0, done=0, result=0 on the next cycle. Then a random regression of 10k ops at W=32 and W=16 against a reference model: signed/unsigned, all ops, including 0, -1 and INT_MIN operands.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the EX stage: multi-cycle MULT/MADD/MSUB with a fixed done
// latency, and a restoring radix-2 divider with defined divide-by-zero results.
module mult_div_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MULT_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      start_i,
  input  logic [2:0]                op_i,
  input  logic [DATA_WIDTH-1:0]     operand_1_i,
  input  logic [DATA_WIDTH-1:0]     operand_2_i,
  input  logic [2*DATA_WIDTH-1:0]   hilo_in_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [2*DATA_WIDTH-1:0]   result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
  localparam logic [W-1:0] ONES_W    = {W{1'b1}};
  localparam logic [W-1:0] ONE_W     = W'(1);
  localparam logic [W-1:0] MUL_LAST  = W'(MULT_STAGES - 1);
  localparam logic [W-1:0] ITER_LAST = W'(W - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_PREP = 3'd2,
    ST_DIV_ITER = 3'd3,
    ST_DIV_FIX  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W2-1:0]   hilo_q, hilo_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quot_q, quot_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            done_q, done_d;
  logic [W2-1:0]   result_q, result_d;

  logic            signed_op;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W2-1:0]   mul_a, mul_b, product, mul_res;
  logic [W:0]      rem_sh, rem_diff;
  logic            quot_bit;

  assign signed_op = ~op_q[0];
  assign a_neg     = signed_op & a_q[W-1];
  assign b_neg     = signed_op & b_q[W-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  assign mul_a   = signed_op ? {{W{a_q[W-1]}}, a_q} : {ZERO_W, a_q};
  assign mul_b   = signed_op ? {{W{b_q[W-1]}}, b_q} : {ZERO_W, b_q};
  assign product = mul_a * mul_b;
  assign mul_res = (op_q[2:1] == 2'b10) ? (hilo_q + product) :
                   (op_q[2:1] == 2'b11) ? (hilo_q - product) : product;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh   = {rem_q, quot_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign quot_bit = ~rem_diff[W];

  // Next-state and datapath updates; flush aborts without touching the result.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    hilo_d     = hilo_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    done_d     = 1'b0;
    result_d   = result_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d    = op_i;
            a_d     = operand_1_i;
            b_d     = operand_2_i;
            hilo_d  = hilo_in_i;
            cnt_d   = ZERO_W;
            state_d = (op_i[2:1] == 2'b01) ? ST_DIV_PREP : ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            result_d = mul_res;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
        ST_DIV_PREP: begin
          if (b_q == ZERO_W) begin
            quot_d     = ONES_W;
            rem_d      = a_q;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            state_d    = ST_DIV_FIX;
          end else begin
            quot_d     = a_mag;
            rem_d      = ZERO_W;
            b_d        = b_mag;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            cnt_d      = ZERO_W;
            state_d    = ST_DIV_ITER;
          end
        end
        ST_DIV_ITER: begin
          rem_d  = quot_bit ? rem_diff[W-1:0] : rem_sh[W-1:0];
          quot_d = {quot_q[W-2:0], quot_bit};
          if (cnt_q == ITER_LAST) begin
            state_d = ST_DIV_FIX;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
        ST_DIV_FIX: begin
          result_d = {(neg_rem_q ? -rem_q : rem_q), (neg_quot_q ? -quot_q : quot_q)};
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      a_q        <= ZERO_W;
      b_q        <= ZERO_W;
      hilo_q     <= {W2{1'b0}};
      cnt_q      <= ZERO_W;
      rem_q      <= ZERO_W;
      quot_q     <= ZERO_W;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= {W2{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hilo_q     <= hilo_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level reference model checked every cycle,
// directed vectors with hand-computed results, and a randomised operand sweep.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic [2*W-1:0] hilo = '0;
  logic          busy_o, done_o;
  logic [2*W-1:0] result_o;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  mult_div_unit #(.DATA_WIDTH(W), .MULT_STAGES(MS)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start), .op_i(op),
    .operand_1_i(opa), .operand_2_i(opb), .hilo_in_i(hilo),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result computed with plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] h);
    longint sa64, sb64;
    logic [63:0] prod;
    int sa, sb, q, r;
    sa64 = $signed(a);
    sb64 = $signed(b);
    if (o == 3'd2 || o == 3'd3) begin
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (o == 3'd3) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
      return {r, q};
    end
    prod = o[0] ? ({32'h0, a} * {32'h0, b}) : 64'(sa64 * sb64);
    if (o == 3'd4 || o == 3'd5) return h + prod;
    if (o == 3'd6 || o == 3'd7) return h - prod;
    return prod;
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd2 || o == 3'd3) return (b == 32'h0) ? 2 : W + 2;
    return MS;
  endfunction

  // Model: cycles remaining until the done edge, pending result, visible outputs.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_left <= 0;
      end else if (m_left == 1) begin
        m_left <= 0; m_done <= 1'b1; m_res <= m_pend;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left <= lat_of(op, opb);
        m_pend <= ref_op(op, opa, opb, hilo);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", {63'h0, busy_o}, {63'h0, m_left != 0});
      chk("cyc done", {63'h0, done_o}, {63'h0, m_done});
      chk("cyc result", result_o, m_res);
    end
  end

  task automatic issue(input bit b2b, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h, output int lat);
    int n;
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; hilo = h;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = done_o ? n - 1 : -1;
  endtask

  task automatic dir(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] h,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    chk({name, " model"}, ref_op(o, a, b, h), exp);
    issue(1'b0, o, a, b, h, lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, result_o, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("reset busy", {63'h0, busy_o}, 64'h0);
    chk("reset done", {63'h0, done_o}, 64'h0);
    chk("reset result", result_o, 64'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    dir("MULT",  3'd0, 32'hFFFF_FFFF, 32'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    dir("MULTU", 3'd1, 32'hFFFF_FFFF, 32'h2, 64'h0, 64'h0000_0001_FFFF_FFFE, 2);
    dir("MADD",  3'd4, 32'hFFFF_FFFD, 32'h5, 64'h10, 64'h1, 2);
    dir("MSUBU", 3'd7, 32'h1, 32'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    dir("MSUB",  3'd6, 32'h2, 32'hFFFF_FFFD, 64'h0, 64'h6, 2);
    dir("DIV neg", 3'd2, 32'hFFFF_FFF9, 32'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    dir("DIVU",  3'd3, 32'h7, 32'h2, 64'h0, 64'h0000_0001_0000_0003, 34);
    dir("DIV ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, 34);
    dir("DIV by0 s", 3'd2, 32'hFFFF_FFF9, 32'h0, 64'h0, 64'hFFFF_FFF9_FFFF_FFFF, 2);
    dir("DIVU by0", 3'd3, 32'h1234, 32'h0, 64'h0, 64'h0000_1234_FFFF_FFFF, 2);

    // Divide with start held while busy, flushed in its tenth cycle.
    @(negedge clk);
    start = 1'b1; op = 3'd2; opa = 32'd100; opb = 32'd7;
    @(posedge clk);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      opa = $urandom;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("flush busy", {63'h0, busy_o}, 64'h0);
    chk("flush done", {63'h0, done_o}, 64'h0);
    chk("flush result kept", result_o, 64'h0000_1234_FFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("flush+start busy", {63'h0, busy_o}, 64'h0);
    flush = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a divide.
    start = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", {63'h0, busy_o}, 64'h0);
    chk("rst done", {63'h0, done_o}, 64'h0);
    chk("rst result", result_o, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      issue(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick(),
            {$urandom, $urandom}, lat);
      chk("rand done seen", {63'h0, done_o}, 64'h1);
      if (!done_o) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
